// File: rtl/ysyx_22041752_mem_arbiter_pkg.sv
// Shared types and width defaults for the IFU/EXU memory arbiter.
// Imported by the interface, the round-robin grant logic and the arbiter top.
package ysyx_22041752_mem_arbiter_pkg;

  localparam int SRAM_ADDR_WD = 64;
  localparam int SRAM_DATA_WD = 64;
  localparam int SRAM_WEN_WD  = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INST_BUSY = 2'd1,
    ST_DATA_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  function automatic arb_state_e busy_state(grant_e g);
    return (g == GRANT_DATA) ? ST_DATA_BUSY : ST_INST_BUSY;
  endfunction

endpackage

// File: rtl/ysyx_22041752_mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port around the arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses the master view.
interface ysyx_22041752_mem_arbiter_if
  import ysyx_22041752_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WD = SRAM_ADDR_WD,
  parameter int DATA_WD = SRAM_DATA_WD,
  parameter int WEN_WD  = SRAM_WEN_WD
);
  logic               inst_en;
  logic [ADDR_WD-1:0] inst_addr;
  logic               inst_kill;
  logic               inst_ready;
  logic [DATA_WD-1:0] inst_rdata;

  logic               data_en;
  logic [WEN_WD-1:0]  data_wen;
  logic [ADDR_WD-1:0] data_addr;
  logic [DATA_WD-1:0] data_wdata;
  logic               data_ready;
  logic [DATA_WD-1:0] data_rdata;

  logic               mem_req;
  logic [WEN_WD-1:0]  mem_wen;
  logic [ADDR_WD-1:0] mem_addr;
  logic [DATA_WD-1:0] mem_wdata;
  logic               mem_ack;
  logic [DATA_WD-1:0] mem_rdata;
  logic               bus_err;

  modport slave (
    input  inst_en, inst_addr, inst_kill,
    output inst_ready, inst_rdata,
    input  data_en, data_wen, data_addr, data_wdata,
    output data_ready, data_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output bus_err
  );

  modport master (
    output inst_en, inst_addr, inst_kill,
    input  inst_ready, inst_rdata,
    output data_en, data_wen, data_addr, data_wdata,
    input  data_ready, data_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/ysyx_22041752_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the
// master that did not win last time.
module ysyx_22041752_rr_arb2
  import ysyx_22041752_mem_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output logic   grant_valid,
  output grant_e grant
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_valid = req_i | req_d;
    grant       = GRANT_INST;
    if (req_i && req_d) begin
      if (last_grant == GRANT_INST) grant = GRANT_DATA;
      else                          grant = GRANT_INST;
    end else if (req_d) begin
      grant = GRANT_DATA;
    end
  end

endmodule

// File: rtl/ysyx_22041752_mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data
// accesses, with registered request, one-cycle ready pulses and a watchdog.
module ysyx_22041752_mem_arbiter
  import ysyx_22041752_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WD = SRAM_ADDR_WD,
  parameter int DATA_WD = SRAM_DATA_WD,
  parameter int WEN_WD  = SRAM_WEN_WD,
  parameter int TIMEOUT = 256
) (
  input logic clk,
  input logic reset,
  ysyx_22041752_mem_arbiter_if.slave bus
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  arb_state_e         state;
  grant_e             last_grant;
  logic               kill_r;
  logic [WD_W-1:0]    wd_cnt;
  logic               mem_req_r;
  logic [WEN_WD-1:0]  mem_wen_r;
  logic [ADDR_WD-1:0] mem_addr_r;
  logic [DATA_WD-1:0] mem_wdata_r;

  logic   grant_valid;
  grant_e grant;
  logic   busy, wd_expired, done, timeout;

  ysyx_22041752_rr_arb2 u_rr_arb2 (
    .req_i       (bus.inst_en & ~bus.inst_kill),
    .req_d       (bus.data_en),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign busy       = (state == ST_INST_BUSY) || (state == ST_DATA_BUSY);
  assign wd_expired = (wd_cnt == WD_MAX);
  assign done       = busy && (bus.mem_ack || wd_expired);
  // An ack arriving on the last watchdog cycle still counts as a normal completion.
  assign timeout    = busy && wd_expired && !bus.mem_ack;

  assign bus.inst_ready = (state == ST_INST_BUSY) && done && !kill_r && !bus.inst_kill;
  assign bus.data_ready = (state == ST_DATA_BUSY) && done;
  assign bus.inst_rdata = (bus.inst_ready && bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.data_rdata = (bus.data_ready && bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.bus_err    = timeout;

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_wen   = mem_wen_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_INST;
      kill_r      <= 1'b0;
      wd_cnt      <= '0;
      mem_req_r   <= 1'b0;
      // NOTE: the latched request fields are reset too, so the memory port reads all-zero after reset.
      mem_wen_r   <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          kill_r <= 1'b0;
          if (grant_valid) begin
            state      <= busy_state(grant);
            last_grant <= grant;
            mem_req_r  <= 1'b1;
            if (grant == GRANT_DATA) begin
              mem_wen_r   <= bus.data_wen;
              mem_addr_r  <= bus.data_addr;
              mem_wdata_r <= bus.data_wdata;
            end else begin
              mem_wen_r   <= '0;
              mem_addr_r  <= bus.inst_addr;
              mem_wdata_r <= '0;
            end
          end
        end
        ST_INST_BUSY, ST_DATA_BUSY: begin
          if (done) begin
            state     <= ST_IDLE;
            mem_req_r <= 1'b0;
            wd_cnt    <= '0;
            kill_r    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (state == ST_INST_BUSY && bus.inst_kill) kill_r <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
